// File: rtl/dispatch_buffer.sv
// rtl/dispatch_buffer.sv - decoded-instruction buffer that resolves head operands and dispatches to ROB/RS/LSB
//
// Purpose: a DEPTH-entry circular FIFO between decode and issue. The head entry's
// source operands are resolved combinationally (CDB snoop, then ROB, then regfile).
// When the head is popped, the registered dispatch bundle and one-cycle ena_* strobes
// are presented on the following cycle.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   in_valid/in_ready + in_*              : push from decode (op 0 is a NOP and is dropped)
//   rs1_to_reg/rs2_to_reg, V*/Q*_from_reg : regfile lookup for the head entry
//   Q*_to_rob, Q*_ready_from_rob, V*_from_rob : ROB lookup for pending tags
//   rob_full/rs_full/lsb_full, rob_id_from_rob : downstream backpressure and next ROB tag
//   cdb_valid/cdb_rob_id/cdb_result       : CDB_PORTS snooped result buses, port k at slice k
//   misbranch                             : flush
//   ena_to_rob/rs/lsb/reg, out_*          : registered dispatch strobes and payload
//   perf_dispatched, perf_stall           : performance counters
//
// Optional feature: define DISPATCH_PERF_EN to build the performance counters;
// otherwise both perf outputs are tied to zero.

module dispatch_buffer #(
  parameter int DEPTH     = 4,
  parameter int CDB_PORTS = 2,
  parameter int ROB_ID_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [5:0]                    in_op,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [31:0]                   in_imm,
  input  logic [31:0]                   in_pc,
  input  logic [31:0]                   in_rollback_pc,
  input  logic                          in_is_ls,
  input  logic                          in_is_store,
  input  logic                          in_is_jump,
  input  logic                          in_pred_jump,
  output logic [4:0]                    rs1_to_reg,
  output logic [4:0]                    rs2_to_reg,
  input  logic [31:0]                   V1_from_reg,
  input  logic [31:0]                   V2_from_reg,
  input  logic [ROB_ID_W-1:0]           Q1_from_reg,
  input  logic [ROB_ID_W-1:0]           Q2_from_reg,
  output logic [ROB_ID_W-1:0]           Q1_to_rob,
  output logic [ROB_ID_W-1:0]           Q2_to_rob,
  input  logic                          Q1_ready_from_rob,
  input  logic                          Q2_ready_from_rob,
  input  logic [31:0]                   V1_from_rob,
  input  logic [31:0]                   V2_from_rob,
  input  logic                          rob_full,
  input  logic                          rs_full,
  input  logic                          lsb_full,
  input  logic [ROB_ID_W-1:0]           rob_id_from_rob,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_ID_W-1:0] cdb_rob_id,
  input  logic [CDB_PORTS*32-1:0]       cdb_result,
  input  logic                          misbranch,
  output logic                          ena_to_rob,
  output logic                          ena_to_rs,
  output logic                          ena_to_lsb,
  output logic                          ena_to_reg,
  output logic [5:0]                    out_op,
  output logic [4:0]                    out_rd,
  output logic [31:0]                   out_V1,
  output logic [31:0]                   out_V2,
  output logic [ROB_ID_W-1:0]           out_Q1,
  output logic [ROB_ID_W-1:0]           out_Q2,
  output logic [31:0]                   out_imm,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   out_rollback_pc,
  output logic                          out_is_store,
  output logic                          out_is_jump,
  output logic                          out_pred_jump,
  output logic [ROB_ID_W-1:0]           out_rob_id,
  output logic [31:0]                   perf_dispatched,
  output logic [31:0]                   perf_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] rollback_pc;
    logic        is_ls;
    logic        is_store;
    logic        is_jump;
    logic        pred_jump;
  } entry_t;

  typedef struct packed {
    logic [5:0]          op;
    logic [4:0]          rd;
    logic [31:0]         v1;
    logic [31:0]         v2;
    logic [ROB_ID_W-1:0] q1;
    logic [ROB_ID_W-1:0] q2;
    logic [31:0]         imm;
    logic [31:0]         pc;
    logic [31:0]         rollback_pc;
    logic                is_store;
    logic                is_jump;
    logic                pred_jump;
    logic [ROB_ID_W-1:0] rob_id;
  } out_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  out_t               out_q, out_d;
  logic [3:0]         ena_q, ena_d;     // {rob, rs, lsb, reg}

  entry_t             head_e;
  entry_t             in_e;
  logic               push, pop, flush;
  logic [31:0]        v1_res, v2_res;
  logic [ROB_ID_W-1:0] q1_res, q2_res;

  // Tag 0 means "no dependency", so the regfile value is used as-is. Otherwise the
  // lowest-index matching CDB port wins, then a ready ROB entry, then the pending tag.
  function automatic logic [32+ROB_ID_W-1:0] resolve(
    input logic [ROB_ID_W-1:0]           q_reg,
    input logic [31:0]                   v_reg,
    input logic                          q_ready,
    input logic [31:0]                   v_rob,
    input logic [CDB_PORTS-1:0]          c_valid,
    input logic [CDB_PORTS*ROB_ID_W-1:0] c_id,
    input logic [CDB_PORTS*32-1:0]       c_res
  );
    logic                hit;
    logic [31:0]         v;
    logic [ROB_ID_W-1:0] q;
    hit = 1'b0;
    v   = v_reg;
    q   = q_reg;
    if (q_reg != '0) begin
      for (int k = 0; k < CDB_PORTS; k++) begin
        if (!hit && c_valid[k] && (c_id[k*ROB_ID_W +: ROB_ID_W] == q_reg)) begin
          hit = 1'b1;
          v   = c_res[k*32 +: 32];
          q   = '0;
        end
      end
      if (!hit && q_ready) begin
        v = v_rob;
        q = '0;
      end
    end
    return {v, q};
  endfunction

  assign head_e     = mem_q[head_q];
  assign rs1_to_reg = head_e.rs1;
  assign rs2_to_reg = head_e.rs2;
  assign Q1_to_rob  = Q1_from_reg;
  assign Q2_to_rob  = Q2_from_reg;
  assign in_ready   = (count_q < CNT_W'(DEPTH));

  assign {v1_res, q1_res} = resolve(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, V1_from_rob,
                                    cdb_valid, cdb_rob_id, cdb_result);
  assign {v2_res, q2_res} = resolve(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, V2_from_rob,
                                    cdb_valid, cdb_rob_id, cdb_result);

  always_comb begin
    in_e.op          = in_op;
    in_e.rd          = in_rd;
    in_e.rs1         = in_rs1;
    in_e.rs2         = in_rs2;
    in_e.imm         = in_imm;
    in_e.pc          = in_pc;
    in_e.rollback_pc = in_rollback_pc;
    in_e.is_ls       = in_is_ls;
    in_e.is_store    = in_is_store;
    in_e.is_jump     = in_is_jump;
    in_e.pred_jump   = in_pred_jump;
  end

  // Flush beats both push and pop; with rdy low nothing moves.
  always_comb begin
    flush = rdy && misbranch;
    pop   = rdy && !misbranch && (count_q != '0) && !rob_full &&
            !(head_e.is_ls ? lsb_full : rs_full);
    push  = rdy && !misbranch && in_valid && in_ready && (in_op != 6'd0);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[tail_q] = in_e;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Strobes last exactly one cycle; the payload holds between dispatches.
  // Fields the target unit does not consume are zeroed.
  always_comb begin
    ena_d = 4'b0000;
    out_d = out_q;
    if (pop) begin
      ena_d        = {1'b1, !head_e.is_ls, head_e.is_ls, 1'b1};
      out_d.op     = head_e.op;
      out_d.rd     = head_e.rd;
      out_d.v1     = v1_res;
      out_d.q1     = q1_res;
      out_d.v2     = v2_res;
      out_d.q2     = q2_res;
      out_d.imm    = head_e.imm;
      out_d.pc     = head_e.pc;
      out_d.rob_id = rob_id_from_rob;
      if (head_e.is_ls) begin
        out_d.is_store    = head_e.is_store;
        out_d.is_jump     = 1'b0;
        out_d.pred_jump   = 1'b0;
        out_d.rollback_pc = '0;
      end else begin
        out_d.is_store    = 1'b0;
        out_d.is_jump     = head_e.is_jump;
        out_d.pred_jump   = head_e.pred_jump;
        out_d.rollback_pc = head_e.rollback_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ena_q   <= '0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ena_q   <= ena_d;
      out_q   <= out_d;
    end
  end

  // Entry storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign {ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg} = ena_q;
  assign out_op          = out_q.op;
  assign out_rd          = out_q.rd;
  assign out_V1          = out_q.v1;
  assign out_V2          = out_q.v2;
  assign out_Q1          = out_q.q1;
  assign out_Q2          = out_q.q2;
  assign out_imm         = out_q.imm;
  assign out_pc          = out_q.pc;
  assign out_rollback_pc = out_q.rollback_pc;
  assign out_is_store    = out_q.is_store;
  assign out_is_jump     = out_q.is_jump;
  assign out_pred_jump   = out_q.pred_jump;
  assign out_rob_id      = out_q.rob_id;

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_disp_q, perf_disp_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_disp_d  = perf_disp_q;
    perf_stall_d = perf_stall_q;
    if (pop) perf_disp_d = perf_disp_q + 32'd1;
    if (rdy && (count_q != '0) && !pop) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_disp_q  <= perf_disp_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_dispatched = perf_disp_q;
  assign perf_stall      = perf_stall_q;
`else
  assign perf_dispatched = 32'd0;
  assign perf_stall      = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_buffer.sv
// tb/tb_dispatch_buffer.sv - directed self-checking bench for dispatch_buffer

module tb_dispatch_buffer;

  localparam int DEPTH     = 4;
  localparam int CDB_PORTS = 2;
  localparam int ROB_ID_W  = 4;
`ifdef DISPATCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  localparam logic [3:0] ENA_NONE = 4'b0000;  // {rob, rs, lsb, reg}
  localparam logic [3:0] ENA_RS   = 4'b1101;
  localparam logic [3:0] ENA_LS   = 4'b1011;

  logic clk = 1'b0;
  logic rst, rdy;
  logic in_valid, in_ready;
  logic [5:0] in_op;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, in_pc, in_rollback_pc;
  logic in_is_ls, in_is_store, in_is_jump, in_pred_jump;
  logic [4:0] rs1_to_reg, rs2_to_reg;
  logic [31:0] V1_from_reg, V2_from_reg;
  logic [ROB_ID_W-1:0] Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob;
  logic Q1_ready_from_rob, Q2_ready_from_rob;
  logic [31:0] V1_from_rob, V2_from_rob;
  logic rob_full, rs_full, lsb_full;
  logic [ROB_ID_W-1:0] rob_id_from_rob;
  logic [CDB_PORTS-1:0] cdb_valid;
  logic [CDB_PORTS*ROB_ID_W-1:0] cdb_rob_id;
  logic [CDB_PORTS*32-1:0] cdb_result;
  logic misbranch;
  logic ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg;
  logic [5:0] out_op;
  logic [4:0] out_rd;
  logic [31:0] out_V1, out_V2, out_imm, out_pc, out_rollback_pc;
  logic [ROB_ID_W-1:0] out_Q1, out_Q2, out_rob_id;
  logic out_is_store, out_is_jump, out_pred_jump;
  logic [31:0] perf_dispatched, perf_stall;

  always #5 clk = ~clk;

  dispatch_buffer #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS), .ROB_ID_W(ROB_ID_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rollback_pc(in_rollback_pc),
    .in_is_ls(in_is_ls), .in_is_store(in_is_store), .in_is_jump(in_is_jump),
    .in_pred_jump(in_pred_jump),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
    .V1_from_rob(V1_from_rob), .V2_from_rob(V2_from_rob),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_id_from_rob(rob_id_from_rob),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
    .misbranch(misbranch),
    .ena_to_rob(ena_to_rob), .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb),
    .ena_to_reg(ena_to_reg),
    .out_op(out_op), .out_rd(out_rd), .out_V1(out_V1), .out_V2(out_V2),
    .out_Q1(out_Q1), .out_Q2(out_Q2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rollback_pc(out_rollback_pc), .out_is_store(out_is_store),
    .out_is_jump(out_is_jump), .out_pred_jump(out_pred_jump),
    .out_rob_id(out_rob_id),
    .perf_dispatched(perf_dispatched), .perf_stall(perf_stall)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_ena(input string tag, input logic [3:0] exp);
    check(tag, {60'd0, ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg}, {60'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic is_ls);
    in_valid       = 1'b1;
    in_op          = op;
    in_rd          = rd;
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_imm         = imm;
    in_pc          = pc;
    in_rollback_pc = pc + 32'd4;
    in_is_ls       = is_ls;
    in_is_store    = 1'b0;
    in_is_jump     = 1'b0;
    in_pred_jump   = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 6'd0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; misbranch = 1'b0;
    idle();
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_rollback_pc = '0;
    in_is_ls = 1'b0; in_is_store = 1'b0; in_is_jump = 1'b0; in_pred_jump = 1'b0;
    V1_from_reg = '0; V2_from_reg = '0; Q1_from_reg = '0; Q2_from_reg = '0;
    Q1_ready_from_rob = 1'b0; Q2_ready_from_rob = 1'b0; V1_from_rob = '0; V2_from_rob = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_id_from_rob = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_result = '0;
    step(); step();
    check_ena("rst_ena", ENA_NONE);
    check("rst_out_V1", out_V1, 0);
    check("rst_out_rob_id", out_rob_id, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_perf_disp", perf_dispatched, 0);
    check("rst_perf_stall", perf_stall, 0);
    rst = 1'b0;

    // add x3: regfile operand, dispatches two cycles after push
    V1_from_reg = 32'd5; V2_from_reg = 32'h22; rob_id_from_rob = 4'd1;
    drive(6'h33, 5'd3, 5'd1, 5'd2, 32'd0, 32'h1000, 1'b0);
    step(); idle();
    check("add_rs1_to_reg", rs1_to_reg, 1);
    check_ena("add_not_yet", ENA_NONE);
    step();
    check_ena("add_ena", ENA_RS);
    check("add_V1", out_V1, 5);
    check("add_Q1", out_Q1, 0);
    check("add_V2", out_V2, 32'h22);
    check("add_rd", out_rd, 3);
    check("add_rob_id", out_rob_id, 1);
    check("add_pc", out_pc, 32'h1000);
    check("add_rollback", out_rollback_pc, 32'h1004);
    step();
    check_ena("add_strobe_1cyc", ENA_NONE);
    check("add_V1_hold", out_V1, 5);

    // lw: rs1 forwarded from CDB port 1, rs2 still pending on tag 7
    Q1_from_reg = 4'd3; cdb_valid = 2'b10;
    cdb_rob_id = {4'd3, 4'd0}; cdb_result = {32'h100, 32'hDEAD};
    Q2_from_reg = 4'd7; V2_from_reg = 32'h77; rob_id_from_rob = 4'd2;
    drive(6'h03, 5'd5, 5'd3, 5'd0, 32'd4, 32'h2000, 1'b1);
    step(); idle(); step();
    check_ena("lw_ena", ENA_LS);
    check("lw_V1", out_V1, 32'h100);
    check("lw_Q1", out_Q1, 0);
    check("lw_Q2", out_Q2, 7);
    check("lw_V2", out_V2, 32'h77);
    check("lw_imm", out_imm, 4);
    check("lw_pc", out_pc, 32'h2000);
    check("lw_rollback_zero", out_rollback_pc, 0);

    // both CDB ports hit tag 2: port 0 wins; rs1 ready in ROB
    cdb_valid = 2'b11; cdb_rob_id = {4'd2, 4'd2}; cdb_result = {32'd9, 32'd7};
    Q2_from_reg = 4'd2; Q1_from_reg = 4'd4; Q1_ready_from_rob = 1'b1; V1_from_rob = 32'h44;
    rob_id_from_rob = 4'd3;
    drive(6'h13, 5'd8, 5'd4, 5'd2, 32'd0, 32'h3000, 1'b0);
    step(); idle(); step();
    check_ena("cdbprio_ena", ENA_RS);
    check("cdbprio_V2", out_V2, 7);
    check("cdbprio_Q2", out_Q2, 0);
    check("rob_fwd_V1", out_V1, 32'h44);
    check("rob_fwd_Q1", out_Q1, 0);
    check("cdbprio_rob_id", out_rob_id, 3);
    cdb_valid = '0; Q1_from_reg = '0; Q2_from_reg = '0; Q1_ready_from_rob = 1'b0;

    // rob_full blocks dispatch until released
    rob_full = 1'b1;
    drive(6'h33, 5'd9, 5'd1, 5'd2, 32'd0, 32'h3100, 1'b0);
    step(); idle(); step();
    check_ena("robfull_hold0", ENA_NONE);
    step();
    check_ena("robfull_hold1", ENA_NONE);
    rob_full = 1'b0;
    step();
    check_ena("robfull_release", ENA_RS);
    check("robfull_rd", out_rd, 9);

    // NOP is accepted but never dispatched
    drive(6'h00, 5'd10, 5'd1, 5'd2, 32'd0, 32'h3200, 1'b0);
    step(); idle(); step();
    check_ena("nop_drop0", ENA_NONE);
    step();
    check_ena("nop_drop1", ENA_NONE);

    // fill to DEPTH under rs_full, overflow push dropped, then drain
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_perf_disp", perf_dispatched, 0);
    rs_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(6'h33, 5'(12 + i), 5'd1, 5'd2, 32'd0, 32'h4000 + 32'(i * 4), 1'b0);
      step();
      check_ena($sformatf("fill_ena%0d", i), ENA_NONE);
    end
    check("full_in_ready", in_ready, 0);
    drive(6'h33, 5'd20, 5'd1, 5'd2, 32'd0, 32'h4100, 1'b0);
    step();
    check_ena("full_hold0", ENA_NONE);
    step();
    check_ena("full_hold1", ENA_NONE);
    idle();
    check("full_perf_stall", perf_stall, PERF_ON ? 5 : 0);
    rs_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_ena($sformatf("drain_ena%0d", i), ENA_RS);
      check($sformatf("drain_rd%0d", i), out_rd, 12 + i);
    end
    step();
    check_ena("drain_no5th", ENA_NONE);
    check("drain_perf_disp", perf_dispatched, PERF_ON ? 4 : 0);
    check("drain_perf_stall", perf_stall, PERF_ON ? 5 : 0);
    check("drain_in_ready", in_ready, 1);

    // flush with three entries and a simultaneous push
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(6'h33, 5'(24 + i), 5'd1, 5'd2, 32'd0, 32'h5000, 1'b0);
      step();
    end
    misbranch = 1'b1;
    drive(6'h33, 5'd27, 5'd1, 5'd2, 32'd0, 32'h5100, 1'b0);
    step();
    misbranch = 1'b0; idle();
    check_ena("flush_ena", ENA_NONE);
    check("flush_in_ready", in_ready, 1);
    rs_full = 1'b0;
    step();
    check_ena("flush_empty0", ENA_NONE);
    step();
    check_ena("flush_empty1", ENA_NONE);
    drive(6'h33, 5'd28, 5'd1, 5'd2, 32'd0, 32'h5200, 1'b0);
    step(); idle(); step();
    check_ena("postflush_ena", ENA_RS);
    check("postflush_rd", out_rd, 28);

    // reset mid-operation discards entries and clears outputs
    rs_full = 1'b1;
    drive(6'h33, 5'd29, 5'd1, 5'd2, 32'd0, 32'h6000, 1'b0);
    step();
    drive(6'h33, 5'd30, 5'd1, 5'd2, 32'd0, 32'h6004, 1'b0);
    step(); idle();
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_out_rd", out_rd, 0);
    check("midrst_out_V1", out_V1, 0);
    rs_full = 1'b0;
    step();
    check_ena("midrst_discard0", ENA_NONE);
    step();
    check_ena("midrst_discard1", ENA_NONE);

    // rdy low freezes everything with two entries queued
    rs_full = 1'b1;
    drive(6'h33, 5'd16, 5'd1, 5'd2, 32'd0, 32'h7000, 1'b0);
    step();
    drive(6'h33, 5'd17, 5'd1, 5'd2, 32'd0, 32'h7004, 1'b0);
    step();
    rdy = 1'b0; rs_full = 1'b0;
    drive(6'h33, 5'd18, 5'd1, 5'd2, 32'd0, 32'h7008, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_ena($sformatf("rdy0_ena%0d", i), ENA_NONE);
    end
    idle();
    check("rdy0_perf_stall", perf_stall, PERF_ON ? 1 : 0);
    check("rdy0_perf_disp", perf_dispatched, 0);
    rdy = 1'b1;
    step();
    check_ena("rdy1_ena0", ENA_RS);
    check("rdy1_rd0", out_rd, 16);
    step();
    check_ena("rdy1_ena1", ENA_RS);
    check("rdy1_rd1", out_rd, 17);
    step();
    check_ena("rdy1_empty", ENA_NONE);
    check("rdy1_perf_disp", perf_dispatched, PERF_ON ? 2 : 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, instruction-buffer entries (power of two, 2..16).
REQ-002 Parameter CDB_PORTS, default 2, number of broadcast result buses snooped (1..4).
REQ-003 Parameter ROB_ID_W, default 4, ROB tag width; tag 0 reserved as "no dependency".
REQ-004 clk  in  1  clock; rst  in  1  reset, synchronous, active-high; rdy  in  1  global enable.
REQ-005 in_valid/in_ready  in/out  1/1  decoded-instruction push handshake from fetch/decode.
REQ-006 in_op 6, in_rd/in_rs1/in_rs2 5 each, in_imm 32, in_pc 32, in_rollback_pc 32; in_is_ls, in_is_store, in_is_jump, in_pred_jump 1 each; all inputs.
REQ-007 rs1_to_reg, rs2_to_reg  out  5  head-entry source registers; V1/V2_from_reg  in  32; Q1/Q2_from_reg  in  ROB_ID_W.
REQ-008 Q1/Q2_to_rob  out  ROB_ID_W  tag queries; Q1/Q2_ready_from_rob  in  1; V1/V2_from_rob  in  32.
REQ-009 rob_full, rs_full, lsb_full  in  1  downstream backpressure; rob_id_from_rob  in  ROB_ID_W  next free tag.
REQ-010 cdb_valid  in  CDB_PORTS; cdb_rob_id  in  CDB_PORTS*ROB_ID_W; cdb_result  in  CDB_PORTS*32  (port k at slice k).
REQ-011 misbranch  in  1  pipeline flush.
REQ-012 ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg  out  1  one-cycle dispatch strobes.
REQ-013 out_op 6, out_rd 5, out_V1/out_V2 32, out_Q1/out_Q2 ROB_ID_W, out_imm 32, out_pc 32, out_rollback_pc 32, out_is_store/out_is_jump/out_pred_jump 1, out_rob_id ROB_ID_W; all registered outputs.
REQ-014 perf_dispatched, perf_stall  out  32  performance counters.

Function
REQ-015 Circular FIFO of DEPTH entries; in_ready = (count < DEPTH); push on in_valid & in_ready & rdy & in_op != 0 (op 0 = NOP, accepted but discarded).
REQ-016 Pop (dispatch) when rdy & count > 0 & !misbranch & !rob_full & !(head.is_ls ? lsb_full : rs_full).
REQ-017 Push and pop in one cycle SHALL both take effect; count unchanged; pointers wrap modulo DEPTH.
REQ-018 Operand resolution at head, combinational, per source: CDB port match (valid & id == Q_from_reg & Q != 0, lowest index wins) -> V=cdb_result, Q=0; else Q_ready_from_rob -> V=V_from_rob, Q=0; else V/Q from regfile.
REQ-019 On pop, the cycle after: ena_to_rob = ena_to_reg = 1; ena_to_lsb = head.is_ls; ena_to_rs = !head.is_ls; out_* loaded from head and resolved operands; out_rob_id = rob_id_from_rob.
REQ-020 Non-target operand outputs are driven to zero on dispatch (LS dispatch does not zero out_pc).
REQ-021 Any cycle without pop (rdy high) SHALL drive all ena_* low; out_* data hold.
REQ-022 misbranch: count, head, tail cleared next cycle; all ena_* low; a push in the same cycle is dropped; flush beats pop.
REQ-023 rdy low: no push, pop, flush, or counter change; all registers hold.
REQ-024 Dispatch latency: instruction at head with no backpressure appears on ena_* exactly one cycle after the pop cycle; an entry pushed into an empty buffer pops one cycle after push.

Reset
REQ-025 rst SHALL clear head, tail, count, all ena_*, out_* (to 0), perf counters; reset has priority over rdy and misbranch; reset mid-operation discards all entries.

Configuration
REQ-026 Macro DISPATCH_PERF_EN: defined -> perf_dispatched increments per pop and perf_stall increments per cycle with count > 0 & rdy & no pop, both wrap at 2^32; undefined -> both outputs constant 0 and no counter registers.

Verification
REQ-027 Push add x3 (rs1=x1, Q1_from_reg=0, V1=5) into empty buffer -> two cycles later ena_to_rs=1, ena_to_rob=1, out_V1=5, out_Q1=0.
REQ-028 Head lw with Q1_from_reg=3, cdb_valid=2'b10, port1 id=3 result=0x100 -> ena_to_lsb=1, out_V1=0x100, out_Q1=0.
REQ-029 Push 4 instrs with rs_full=1 (DEPTH=4) -> in_ready=0 after fourth, no ena_*; release rs_full -> four consecutive ena_to_rs pulses, perf_stall counts held cycles.
REQ-030 count=3, misbranch=1 with simultaneous in_valid -> next cycle count=0, in_ready=1, all ena_* 0.
REQ-031 Both CDB ports valid with id=2 (results 7, 9), Q2_from_reg=2 -> out_V2=7.
REQ-032 rdy=0 for 3 cycles with count=2 -> no ena_*, count stays 2, perf counters unchanged.
